// File: rtl/ranging_pkg.sv
// Shared types and constant helpers for the ultrasonic ranging scheduler.
package ranging_pkg;

    localparam int RAW_W = 21;
    localparam int TMR_W = 23;
    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        HOLDOFF,
        FIRE,
        WAIT,
        CLASSIFY
    } state_t;

    typedef enum logic [1:0] {
        NEAR,
        FAR,
        NEUTRAL
    } class_t;

    // Echo width in clk cycles for a distance: 58 us per cm, round trip.
    function automatic logic [RAW_W-1:0] cm_to_count(input int cm, input int mhz);
        return RAW_W'(cm * 58 * mhz);
    endfunction

    function automatic logic [TMR_W-1:0] ms_to_cycles(input int ms, input int mhz);
        return TMR_W'(ms * 1000 * mhz - 1);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/median3.sv
// Combinational median of three unsigned values.
module median3 #(
    parameter int W = 21
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] med
);

    logic [W-1:0] lo;
    logic [W-1:0] hi;

    always_comb begin
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        if (c < lo)
            med = lo;
        else if (c > hi)
            med = hi;
        else
            med = c;
    end

endmodule

// File: rtl/ranging_scheduler.sv
// Periodic ranger sequencing with watchdog, hysteresis and debounce.
// Define RANGING_MEDIAN3_EN to classify on a 3-sample running median.
module ranging_scheduler
    import ranging_pkg::*;
#(
    parameter int CLK_MHZ     = 50,
    parameter int NEAR_CM     = 50,
    parameter int FAR_CM      = 70,
    parameter int NEAR_N      = 3,
    parameter int FAR_N       = 5,
    parameter int HOLDOFF_MS  = 60,
    parameter int WATCHDOG_MS = 30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output logic             start,
    input  logic [RAW_W-1:0] distance_raw,
    input  logic             new_measure,
    input  logic             timeout,
    output logic             screen_off,
    output logic             sample_valid,
    output logic [RAW_W-1:0] last_raw,
    output logic             sensor_fault
);

    localparam logic [RAW_W-1:0] NEAR_COUNT = cm_to_count(NEAR_CM, CLK_MHZ);
    localparam logic [RAW_W-1:0] FAR_COUNT  = cm_to_count(FAR_CM, CLK_MHZ);
    localparam logic [TMR_W-1:0] HOLD_LD    = ms_to_cycles(HOLDOFF_MS, CLK_MHZ);
    localparam logic [TMR_W-1:0] WDOG_LD    = ms_to_cycles(WATCHDOG_MS, CLK_MHZ);
    localparam logic [CNT_W-1:0] NEAR_TH    = CNT_W'(NEAR_N);
    localparam logic [CNT_W-1:0] FAR_TH     = CNT_W'(FAR_N);

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic [CNT_W-1:0] near_cnt;
    logic [CNT_W-1:0] far_cnt;
    logic [CNT_W-1:0] near_nx;
    logic [CNT_W-1:0] far_nx;
    logic [RAW_W-1:0] sample;
    logic             cls_done;
    class_t           cls;

    assign sample = timeout ? {RAW_W{1'b1}} : distance_raw;

`ifdef RANGING_MEDIAN3_EN
    logic [RAW_W-1:0] h0, h1, h2;
    logic [RAW_W-1:0] med;
    logic [RAW_W-1:0] med_q;
    logic [1:0]       fill;
    logic             phase;

    median3 #(.W(RAW_W)) u_median3 (
        .a   (h0),
        .b   (h1),
        .c   (h2),
        .med (med)
    );

    assign cls_done = phase;
`else
    logic to_q;

    assign cls_done = 1'b1;
`endif

    always_comb begin
        cls = NEUTRAL;
`ifdef RANGING_MEDIAN3_EN
        if (fill == 2'd3) begin
            if (med_q < NEAR_COUNT)
                cls = NEAR;
            else if (med_q >= FAR_COUNT)
                cls = FAR;
        end
`else
        if (to_q)
            cls = FAR;
        else if (last_raw < NEAR_COUNT)
            cls = NEAR;
        else if (last_raw >= FAR_COUNT)
            cls = FAR;
`endif
        near_nx = near_cnt;
        far_nx  = far_cnt;
        unique case (cls)
            NEAR: begin
                near_nx = sat_inc(near_cnt);
                far_nx  = '0;
            end
            FAR: begin
                far_nx  = sat_inc(far_cnt);
                near_nx = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            timer        <= '0;
            near_cnt     <= '0;
            far_cnt      <= '0;
            start        <= 1'b0;
            screen_off   <= 1'b0;
            sample_valid <= 1'b0;
            last_raw     <= '0;
            sensor_fault <= 1'b0;
`ifdef RANGING_MEDIAN3_EN
            h0    <= '0;
            h1    <= '0;
            h2    <= '0;
            med_q <= '0;
            fill  <= '0;
            phase <= 1'b0;
`else
            to_q <= 1'b0;
`endif
        end else begin
            start        <= 1'b0;
            sample_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (enable) begin
                        timer <= HOLD_LD;
                        state <= HOLDOFF;
                    end
                end
                HOLDOFF: begin
                    if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else if (enable) begin
                        start <= 1'b1;
                        state <= FIRE;
                    end else begin
                        // Leaving service: forget the debounce history.
                        screen_off <= 1'b0;
                        near_cnt   <= '0;
                        far_cnt    <= '0;
`ifdef RANGING_MEDIAN3_EN
                        fill <= '0;
`endif
                        state <= IDLE;
                    end
                end
                FIRE: begin
                    timer <= WDOG_LD;
                    state <= WAIT;
                end
                WAIT: begin
                    if (new_measure) begin
                        last_raw <= sample;
`ifdef RANGING_MEDIAN3_EN
                        h0    <= sample;
                        h1    <= h0;
                        h2    <= h1;
                        fill  <= (fill == 2'd3) ? fill : fill + 2'd1;
                        phase <= 1'b0;
`else
                        to_q <= timeout;
`endif
                        state <= CLASSIFY;
                    end else if (timer == '0) begin
                        sensor_fault <= 1'b1;
                        timer        <= HOLD_LD;
                        state        <= HOLDOFF;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                CLASSIFY: begin
                    if (cls_done) begin
                        near_cnt <= near_nx;
                        far_cnt  <= far_nx;
                        if (near_nx >= NEAR_TH)
                            screen_off <= 1'b1;
                        else if (far_nx >= FAR_TH)
                            screen_off <= 1'b0;
                        sample_valid <= 1'b1;
                        timer        <= HOLD_LD;
                        state        <= HOLDOFF;
                    end
`ifdef RANGING_MEDIAN3_EN
                    else begin
                        med_q <= med;
                        phase <= 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ranging_scheduler.sv
// Scoreboard bench for ranging_scheduler; runs at CLK_MHZ=1 so one
// holdoff/watchdog period is 1000 cycles and raw values scale by 1/50.
module tb_ranging_scheduler;

    localparam int CLK_MHZ    = 1;
    localparam int NEAR_CM    = 50;
    localparam int FAR_CM     = 70;
    localparam int NEAR_N     = 3;
    localparam int FAR_N      = 5;
    localparam int HO         = 1000;
    localparam int WD         = 1000;
    localparam int NEAR_COUNT = NEAR_CM * 58 * CLK_MHZ;
    localparam int FAR_COUNT  = FAR_CM * 58 * CLK_MHZ;
    localparam int R_NEAR     = 2000;
    localparam int R_FAR      = 6000;
    localparam int R_NEU      = 3600;
    localparam int LIMIT      = 3 * HO;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        start;
    logic [20:0] distance_raw = '0;
    logic        new_measure = 1'b0;
    logic        timeout = 1'b0;
    logic        screen_off;
    logic        sample_valid;
    logic [20:0] last_raw;
    logic        sensor_fault;

    ranging_scheduler #(
        .CLK_MHZ     (CLK_MHZ),
        .NEAR_CM     (NEAR_CM),
        .FAR_CM      (FAR_CM),
        .NEAR_N      (NEAR_N),
        .FAR_N       (FAR_N),
        .HOLDOFF_MS  (1),
        .WATCHDOG_MS (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .start        (start),
        .distance_raw (distance_raw),
        .new_measure  (new_measure),
        .timeout      (timeout),
        .screen_off   (screen_off),
        .sample_valid (sample_valid),
        .last_raw     (last_raw),
        .sensor_fault (sensor_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        so;
        logic        fault;
        logic [20:0] lr;
        longint      cyc;
    } exp_t;

    exp_t        sb[$];
    longint      cyc = 0;
    longint      exp_start = -1;
    int          n_chk = 0;
    int          n_err = 0;
    logic        prev_start = 1'b0;
    int          m_near = 0;
    int          m_far = 0;
    logic        m_so = 1'b0;
    logic        m_fault = 1'b0;
    logic [20:0] mh [3];
    int          m_fill = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [20:0] med3(input logic [20:0] a, input logic [20:0] b,
                                         input logic [20:0] c);
        logic [20:0] t;
        if (a > b) begin t = a; a = b; b = t; end
        if (b > c) begin t = b; b = c; c = t; end
        if (a > b) begin t = a; a = b; b = t; end
        return b;
    endfunction

    task automatic model_clear();
        m_near = 0;
        m_far  = 0;
        m_so   = 1'b0;
        m_fill = 0;
    endtask

    task automatic model_push(input logic [20:0] raw, input logic to, input longint t);
        exp_t        e;
        logic [20:0] v;
        int          cls;
        v   = to ? 21'h1FFFFF : raw;
        e.lr = v;
        cls = 0;
`ifdef RANGING_MEDIAN3_EN
        mh[2] = mh[1];
        mh[1] = mh[0];
        mh[0] = v;
        if (m_fill < 3) m_fill++;
        if (m_fill == 3) begin
            v = med3(mh[0], mh[1], mh[2]);
            if (v < NEAR_COUNT) cls = 1;
            else if (v >= FAR_COUNT) cls = 2;
        end
        e.cyc = t + 3;
`else
        if (to || raw >= FAR_COUNT) cls = 2;
        else if (raw < NEAR_COUNT) cls = 1;
        e.cyc = t + 2;
`endif
        if (cls == 1) begin
            m_near = (m_near < 15) ? m_near + 1 : 15;
            m_far  = 0;
        end else if (cls == 2) begin
            m_far  = (m_far < 15) ? m_far + 1 : 15;
            m_near = 0;
        end
        if (m_near >= NEAR_N) m_so = 1'b1;
        else if (m_far >= FAR_N) m_so = 1'b0;
        e.so    = m_so;
        e.fault = m_fault;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_start = 1'b0;
        end else begin
            if (prev_start) check("start_width", start, 0);
            prev_start = start;
            if (sample_valid) begin
                if (sb.size() == 0) begin
                    check("sv_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sv_cycle", cyc, e.cyc);
                    check("screen_off", screen_off, e.so);
                    check("last_raw", last_raw, e.lr);
                    check("sensor_fault", sensor_fault, e.fault);
                end
                exp_start = cyc + HO;
            end
        end
    end

    task automatic wait_start(output longint s);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (start !== 1'b1 && n < LIMIT);
        check("start_seen", start, 1);
        s = cyc;
        if (exp_start >= 0) check("start_cycle", s, exp_start);
        exp_start = -1;
    endtask

    task automatic respond(input logic [20:0] raw, input logic to, input int d);
        repeat (d - 1) @(negedge clk);
        distance_raw = raw;
        timeout      = to;
        new_measure  = 1'b1;
        model_push(raw, to, cyc);
        @(negedge clk);
        new_measure  = 1'b0;
        timeout      = 1'b0;
        distance_raw = 21'($urandom);
    endtask

    task automatic do_meas(input logic [20:0] raw, input logic to, input int d);
        longint s;
        wait_start(s);
        @(negedge clk);
        respond(raw, to, d);
    endtask

    initial begin
        longint s;
        int     n;
        logic   saw;
        repeat (3) @(negedge clk);
        check("rst_start", start, 0);
        check("rst_screen_off", screen_off, 0);
        check("rst_sample_valid", sample_valid, 0);
        check("rst_last_raw", last_raw, 0);
        check("rst_fault", sensor_fault, 0);

        rst       = 1'b0;
        enable    = 1'b1;
        exp_start = cyc + HO + 1;

        // near, near, far, near, near: debounce restarts; 6th near blanks
        do_meas(R_NEAR, 0, 5);
        do_meas(R_NEAR, 0, 7);
        do_meas(R_FAR, 0, 3);
        do_meas(R_NEAR, 0, 2);
        do_meas(R_NEAR, 0, 9);
        do_meas(R_NEAR, 0, 1);

        for (int i = 0; i < 6; i++) do_meas(R_NEU + 60 * i, 0, 4 + i);
        for (int i = 0; i < 5; i++) do_meas(21'($urandom_range(0, 9999)), 1, 6);

        // threshold edges: NEAR_COUNT-1 is near, FAR_COUNT is far
        for (int i = 0; i < 3; i++) do_meas(21'(NEAR_COUNT - 1), 0, 3);
        do_meas(21'(NEAR_COUNT), 0, 3);
        do_meas(21'(FAR_COUNT - 1), 0, 3);
        for (int i = 0; i < 5; i++) do_meas(21'(FAR_COUNT), 0, 3);

        // result on the watchdog expiry cycle is accepted without a fault
        do_meas(R_NEAR, 0, WD);

        // stray new_measure during holdoff
        repeat (10) @(negedge clk);
        new_measure = 1'b1;
        distance_raw = 21'(R_FAR);
        @(negedge clk);
        new_measure = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stray_sv", sample_valid, 0);
        end

        // watchdog fault
        wait_start(s);
        repeat (WD) @(negedge clk);
        check("fault_early", sensor_fault, 0);
        @(negedge clk);
        check("fault_set", sensor_fault, 1);
        m_fault   = 1'b1;
        exp_start = s + WD + 1 + HO;

        for (int i = 0; i < 3; i++) do_meas(R_NEAR, 0, 2 + i);

        // enable dropped while waiting: result still taken, then idle
        wait_start(s);
        enable = 1'b0;
        @(negedge clk);
        respond(R_NEAR, 0, 3);
        saw = 1'b0;
        for (int i = 0; i < HO + 20; i++) begin
            @(negedge clk);
            if (start === 1'b1) saw = 1'b1;
        end
        check("idle_no_start", saw, 0);
        check("idle_screen_off", screen_off, 0);
        check("idle_fault_kept", sensor_fault, 1);
        model_clear();
        exp_start = -1;
        enable    = 1'b1;
        exp_start = cyc + HO + 1;
        do_meas(R_NEAR, 0, 4);

        // reset during FIRE
        wait_start(s);
        rst = 1'b1;
        @(negedge clk);
        check("rstfire_start", start, 0);
        check("rstfire_screen_off", screen_off, 0);
        check("rstfire_last_raw", last_raw, 0);
        check("rstfire_fault", sensor_fault, 0);
        model_clear();
        m_fault = 1'b0;
        rst       = 1'b0;
        exp_start = cyc + HO + 1;
        do_meas(R_NEAR, 0, 5);

        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ranging_scheduler.md
Name: ranging_scheduler

Overview:
- Sequences the ultrasonic ranger block (start / distance_raw / new_measure / timeout interface) for the TV screen-off system.
- Fires periodic measurements and guards each one with a watchdog.
- Classifies each result against near/far thresholds with hysteresis and consecutive-sample debounce.
- Drives screen_off to the display-blanking logic.

Parameters:
- CLK_MHZ, 50, clock frequency in MHz; must match the ranger instance.
- NEAR_CM, 50, distance in cm below which a sample is "near".
- FAR_CM, 70, distance in cm at or above which a sample is "far"; must exceed NEAR_CM.
- NEAR_N, 3, consecutive near samples needed to assert screen_off (1..15).
- FAR_N, 5, consecutive far samples needed to deassert screen_off (1..15).
- HOLDOFF_MS, 60, gap from one result (or fault) to the next start pulse.
- WATCHDOG_MS, 30, maximum wait for new_measure after start.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  level; 1 = run periodic ranging
- start  out  1  one-cycle pulse to the ranger's start input
- distance_raw  in  21  ranger echo width in clk cycles
- new_measure  in  1  one-cycle pulse from the ranger; result valid
- timeout  in  1  qualifies new_measure; echo exceeded the ranger timeout
- screen_off  out  1  registered; 1 = blank the TV
- sample_valid  out  1  one-cycle pulse when a sample has been classified
- last_raw  out  21  last accepted distance_raw; all-ones on ranger timeout
- sensor_fault  out  1  sticky; the watchdog expired at least once

Behaviour:
- Reset values: start=0, screen_off=0, sample_valid=0, last_raw=0, sensor_fault=0, near_cnt=0, far_cnt=0, timer=0, state=IDLE.
- Constants:
  - NEAR_COUNT = NEAR_CM*58*CLK_MHZ (145000 at defaults); FAR_COUNT = FAR_CM*58*CLK_MHZ (203000).
  - Comparisons are unsigned 21-bit; no divider.
  - Timer is 23 bits, loaded with ms*1000*CLK_MHZ-1 and counting down to 0.
- FSM:
  - IDLE: if enable, load HOLDOFF, go to HOLDOFF. The first start after reset is therefore delayed ≥ HOLDOFF_MS so that a ranger still busy before reset can finish.
  - HOLDOFF: count down. At 0: if enable, go to FIRE; else go to IDLE.
  - FIRE: start=1 for exactly this one cycle; load WATCHDOG; go to WAIT.
  - WAIT:
    - On new_measure: latch the sample, go to CLASSIFY.
    - Else, on timer=0: set sensor_fault, load HOLDOFF, go to HOLDOFF. Debounce counters and screen_off are unchanged.
  - CLASSIFY, 1 cycle:
    - Sample class: near if !timeout and raw<NEAR_COUNT; far if timeout or raw≥FAR_COUNT; otherwise neutral.
    - Counters: near → near_cnt++ (saturating) and far_cnt=0. Far → far_cnt++ (saturating) and near_cnt=0. Neutral → both counters hold.
    - screen_off: set when the updated near_cnt≥NEAR_N; cleared when the updated far_cnt≥FAR_N. Takes effect at the end of the CLASSIFY cycle.
    - sample_valid=1 this cycle.
    - Load HOLDOFF, go to HOLDOFF.
- Latency: new_measure in cycle t → sample_valid and the screen_off update visible at cycle t+2.
- Stray input: new_measure outside WAIT is ignored.
- Enable deasserted:
  - An in-flight WAIT still completes (result or watchdog).
  - HOLDOFF exits to IDLE instead of FIRE.
  - On entry to IDLE with enable=0: screen_off=0, counters cleared; sensor_fault is kept.
- Simultaneous new_measure and watchdog expiry in WAIT: new_measure wins, no fault.
- Mid-operation rst: immediate return to reset values. start is never asserted in the reset cycle.

Optional Feature:
- Macro: RANGING_MEDIAN3_EN.
- With the macro defined:
  - Accepted samples enter a 3-deep shift register; a ranger timeout enters as 21'h1FFFFF.
  - Classification uses the median of the three entries, so CLASSIFY takes 2 cycles and latency becomes t+3.
  - Until 3 samples have been collected since reset or IDLE, each sample is classified neutral.
- Without the macro: each raw sample is classified directly, as above.

Decomposition:
- Package ranging_pkg: FSM state encoding (IDLE, HOLDOFF, FIRE, WAIT, CLASSIFY); sample-class enum (NEAR, FAR, NEUTRAL); the constant functions for the count thresholds and ms-to-cycles conversion.
- Sub-module median3: combinational 3-input 21-bit median, instantiated only under RANGING_MEDIAN3_EN.

Test Plan:
- Timing parameters overridden (HOLDOFF_MS=1, WATCHDOG_MS=1, CLK_MHZ=50); count expectations below use the default NEAR_CM/FAR_CM.
- Reset, enable=1 → first start pulse is exactly 1 cycle wide, 50000 cycles after the IDLE exit; next start arrives 50000 cycles after each sample_valid.
- Three results of raw=100000 → screen_off rises 2 cycles after the 3rd new_measure; two near samples then raw=300000 → screen_off stays 0 and near_cnt=0.
- With screen_off=1: raw=180000 (neutral) ×6 → screen_off stays 1. Then timeout=1 ×5 → screen_off falls after the 5th; last_raw=21'h1FFFFF.
- No new_measure after start → sensor_fault=1 after 50000 cycles and the next start follows; new_measure arriving on the expiry cycle → no fault.
- enable dropped during WAIT → the result is still accepted, then IDLE with screen_off=0; rst asserted during FIRE → start=0 the following cycle.
- RANGING_MEDIAN3_EN: samples 100000, 300000, 100000 → median 100000 (near), and the first two samples are neutral.
